// File: rtl/lbs_play_buffer.sv
// Local-bus sample buffer that replays a loaded block on an AXI-Stream master port.
// Latency: lbs reads return 2 edges after re; first beat 2 cycles after the START write.
// Backpressure: tready stalls the 2-entry skid, and prefetch stops while it is full.
//
// Ports:
//   lbs_clk, rst             sole clock, async active-high reset
//   lbs_addr/din/we/re/dout  local-bus responder (word addressed)
//   axis_tx_*                stream master carrying buffer words, tlast on the final word
//   busy                     high while the block is being played
module lbs_play_buffer #(
    parameter int BUF_BASE  = 12000,
    parameter int BUF_DEPTH = 2304,
    parameter int CTRL_ADDR = 16000,
    parameter int STAT_ADDR = 16001
) (
    input  logic        lbs_clk,
    input  logic        rst,
    input  logic [15:0] lbs_addr,
    input  logic [31:0] lbs_din,
    input  logic        lbs_we,
    input  logic        lbs_re,
    output logic [31:0] lbs_dout,
    output logic        axis_tx_tvalid,
    output logic [31:0] axis_tx_tdata,
    output logic        axis_tx_tlast,
    input  logic        axis_tx_tready,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

    localparam logic [15:0] BUF_LO = 16'(BUF_BASE);
    localparam logic [15:0] BUF_HI = 16'(BUF_BASE + BUF_DEPTH);
    localparam logic [15:0] CTRL_A = 16'(CTRL_ADDR);
    localparam logic [15:0] STAT_A = 16'(STAT_ADDR);

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_STAT = 2'd1;
    localparam logic [1:0] SEL_BUF  = 2'd2;

    state_t      state, state_nxt;
    logic [11:0] fill_len;
    logic        done, err_empty, err_overrun, aborted;

    logic [31:0] mem [BUF_DEPTH];

    // ---------------- bus decode ----------------
    logic        in_buf, ctrl_wr, buf_wr, rd_req;
    logic        cmd_arm, cmd_start, cmd_abort, start_state, start_ok;
    logic [11:0] a_idx, a_idx_p1;

    assign in_buf      = (lbs_addr >= BUF_LO) && (lbs_addr < BUF_HI);
    assign a_idx       = 12'(lbs_addr - BUF_LO);
    assign a_idx_p1    = a_idx + 12'd1;
    assign ctrl_wr     = lbs_we && (lbs_addr == CTRL_A);
    assign buf_wr      = lbs_we && in_buf;
    assign rd_req      = lbs_re && !lbs_we;   // a write in the same cycle wins
    assign cmd_arm     = ctrl_wr && (lbs_din == 32'h0000_5555);
    assign cmd_start   = ctrl_wr && (lbs_din == 32'h0000_8888);
    assign cmd_abort   = ctrl_wr && (lbs_din == 32'h0000_FFFF);
    assign start_state = (state == S_LOAD) || (state == S_DONE);
    assign start_ok    = cmd_start && start_state && (fill_len != 12'd0);

    // ---------------- playback pipeline ----------------
    // Port B read register (b_*) feeds a 2-entry skid; occupancy counts the
    // word in flight so the skid can never overflow.
    logic [11:0] rd_idx;
    logic        fetch_done, b_vld, b_last;
    logic [31:0] ram_b_q;
    logic [32:0] skid [2];
    logic        rp, wp;
    logic [1:0]  cnt, occ_after;
    logic        push, pop, issue, is_last_idx, head_last, last_pop, flush;

    assign axis_tx_tvalid = (cnt != 2'd0);
    assign axis_tx_tdata  = axis_tx_tvalid ? skid[rp][31:0] : 32'd0;
    assign head_last      = skid[rp][32];
    assign axis_tx_tlast  = axis_tx_tvalid && head_last;
    assign busy           = (state == S_PLAY);

    assign push        = b_vld;
    assign pop         = axis_tx_tvalid && axis_tx_tready;
    assign last_pop    = pop && head_last;
    assign occ_after   = cnt + {1'b0, b_vld} - {1'b0, pop};
    assign is_last_idx = (rd_idx == fill_len - 12'd1);
    assign issue       = (state == S_PLAY) && !fetch_done && (occ_after < 2'd2);
    assign flush       = (state == S_PLAY) && (state_nxt != S_PLAY);

    // ---------------- FSM ----------------
    always_ff @(posedge lbs_clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cmd_abort)                          state_nxt = S_IDLE;
        else if (cmd_arm)                       state_nxt = S_LOAD;
        else if (start_ok)                      state_nxt = S_PLAY;
        else if (state == S_PLAY && last_pop)   state_nxt = S_DONE;
    end

    // ---------------- fill length and flags ----------------
    always_ff @(posedge lbs_clk or posedge rst) begin
        if (rst) begin
            fill_len    <= 12'd0;
            done        <= 1'b0;
            err_empty   <= 1'b0;
            err_overrun <= 1'b0;
            aborted     <= 1'b0;
        end else if (cmd_arm) begin
            fill_len    <= 12'd0;
            done        <= 1'b0;
            err_empty   <= 1'b0;
            err_overrun <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            if (cmd_abort && state == S_PLAY)
                aborted <= 1'b1;
            if (cmd_start && start_state && fill_len == 12'd0)
                err_empty <= 1'b1;
            if (start_ok)
                done <= 1'b0;
            if (state == S_PLAY && last_pop && !cmd_abort)
                done <= 1'b1;
            if (buf_wr && state == S_PLAY)
                err_overrun <= 1'b1;
            // Highest written index sets the length; idx+1 tops out at BUF_DEPTH.
            if (buf_wr && state == S_LOAD && a_idx_p1 > fill_len)
                fill_len <= a_idx_p1;
        end
    end

    // ---------------- buffer ports (not reset) ----------------
    logic [31:0] ram_a_q;

    always_ff @(posedge lbs_clk) begin
        if (buf_wr && state == S_LOAD)
            mem[a_idx] <= lbs_din;
        if (rd_req && in_buf)
            ram_a_q <= mem[a_idx];
    end

    always_ff @(posedge lbs_clk) begin
        if (issue)
            ram_b_q <= mem[rd_idx];
        if (push)
            skid[wp] <= {b_last, ram_b_q};
    end

    always_ff @(posedge lbs_clk or posedge rst) begin
        if (rst) begin
            rd_idx     <= 12'd0;
            fetch_done <= 1'b0;
            b_vld      <= 1'b0;
            b_last     <= 1'b0;
            cnt        <= 2'd0;
            rp         <= 1'b0;
            wp         <= 1'b0;
        end else if (flush || start_ok) begin
            rd_idx     <= 12'd0;
            fetch_done <= 1'b0;
            b_vld      <= 1'b0;
            b_last     <= 1'b0;
            cnt        <= 2'd0;
            rp         <= 1'b0;
            wp         <= 1'b0;
        end else begin
            b_vld <= issue;
            if (issue) begin
                rd_idx <= rd_idx + 12'd1;
                b_last <= is_last_idx;
                if (is_last_idx)
                    fetch_done <= 1'b1;
            end
            if (push) wp <= ~wp;
            if (pop)  rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // ---------------- read-back pipeline ----------------
    // Stage 1 captures the RAM word and a status snapshot, stage 2 muxes,
    // lbs_dout loads on the following edge and holds between reads.
    logic        rd1_vld, rd2_vld;
    logic [1:0]  rd1_sel;
    logic [31:0] rd1_stat, rd2_dat, status;

    assign status = {4'd0, fill_len, 11'd0, aborted, err_overrun, err_empty, done, busy};

    always_ff @(posedge lbs_clk or posedge rst) begin
        if (rst) begin
            rd1_vld  <= 1'b0;
            rd1_sel  <= SEL_ZERO;
            rd1_stat <= 32'd0;
            rd2_vld  <= 1'b0;
            rd2_dat  <= 32'd0;
            lbs_dout <= 32'd0;
        end else begin
            rd1_vld  <= rd_req;
            rd1_sel  <= in_buf ? SEL_BUF : ((lbs_addr == STAT_A) ? SEL_STAT : SEL_ZERO);
            rd1_stat <= status;
            rd2_vld  <= rd1_vld;
            case (rd1_sel)
                SEL_BUF:  rd2_dat <= ram_a_q;
                SEL_STAT: rd2_dat <= rd1_stat;
                default:  rd2_dat <= 32'd0;
            endcase
            if (rd2_vld)
                lbs_dout <= rd2_dat;
        end
    end

endmodule

// File: tb/tb_lbs_play_buffer.sv
module tb_lbs_play_buffer;

    localparam int BUF_BASE  = 12000;
    localparam int BUF_DEPTH = 2304;
    localparam logic [15:0] CTRL = 16'd16000;
    localparam logic [15:0] STAT = 16'd16001;

    logic        lbs_clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] lbs_addr = 16'd0;
    logic [31:0] lbs_din = 32'd0;
    logic        lbs_we = 1'b0;
    logic        lbs_re = 1'b0;
    logic [31:0] lbs_dout;
    logic        axis_tx_tvalid;
    logic [31:0] axis_tx_tdata;
    logic        axis_tx_tlast;
    logic        axis_tx_tready = 1'b1;
    logic        busy;

    lbs_play_buffer dut (
        .lbs_clk        (lbs_clk),
        .rst            (rst),
        .lbs_addr       (lbs_addr),
        .lbs_din        (lbs_din),
        .lbs_we         (lbs_we),
        .lbs_re         (lbs_re),
        .lbs_dout       (lbs_dout),
        .axis_tx_tvalid (axis_tx_tvalid),
        .axis_tx_tdata  (axis_tx_tdata),
        .axis_tx_tlast  (axis_tx_tlast),
        .axis_tx_tready (axis_tx_tready),
        .busy           (busy)
    );

    always #5 lbs_clk = ~lbs_clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cyc = 0;
    int          first_vld_cyc = -1;
    int          first_xfer_cyc = -1;
    int          last_xfer_cyc = -1;
    int          xfers = 0;
    bit          rdy_toggle = 1'b0;
    bit          allow_drop = 1'b0;
    logic [32:0] exp_q[$];
    logic [31:0] model [BUF_DEPTH];
    logic [31:0] rd_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // cycle counter, read only at negedges
    initial forever begin
        @(posedge lbs_clk);
        cyc++;
    end

    // tready driver: held high or toggled once per cycle, stable around each negedge
    initial forever begin
        @(posedge lbs_clk);
        #1;
        if (rdy_toggle) axis_tx_tready = ~axis_tx_tready;
        else            axis_tx_tready = 1'b1;
    end

    // stream monitor / scoreboard: a handshake seen at a negedge completes on the next edge
    initial begin
        logic        prev_stall;
        logic [32:0] held;
        logic [32:0] e;
        prev_stall = 1'b0;
        held = 33'd0;
        forever begin
            @(negedge lbs_clk);
            if (axis_tx_tvalid && first_vld_cyc < 0)
                first_vld_cyc = cyc;
            if (prev_stall && axis_tx_tvalid)
                chk("stall_hold", axis_tx_tdata ^ held[31:0], {31'd0, axis_tx_tlast ^ held[32]});
            if (prev_stall && !axis_tx_tvalid && !allow_drop)
                chk("vld_drop_no_xfer", 32'(axis_tx_tvalid), 32'd1);
            if (axis_tx_tvalid && axis_tx_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", axis_tx_tdata, e[31:0]);
                    chk("beat_last", 32'(axis_tx_tlast), 32'(e[32]));
                end
                xfers++;
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
            end
            prev_stall = axis_tx_tvalid && !axis_tx_tready;
            held = {axis_tx_tlast, axis_tx_tdata};
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge lbs_clk);
        lbs_addr = a; lbs_din = d; lbs_we = 1'b1;
        @(negedge lbs_clk);
        lbs_we = 1'b0;
        wr_cyc = cyc;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge lbs_clk);
        lbs_addr = a; lbs_re = 1'b1;
        @(negedge lbs_clk);
        lbs_re = 1'b0;
        @(posedge lbs_clk);
        @(posedge lbs_clk);
        #1 d = lbs_dout;
    endtask

    task automatic load_seq(input int n);
        for (int i = 0; i < n; i++) begin
            model[i] = 32'h11 * (i + 1);
            bus_wr(16'(BUF_BASE + i), model[i]);
        end
    endtask

    task automatic push_block(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1), model[i]});
    endtask

    task automatic clear_stats();
        xfers = 0; first_vld_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || axis_tx_tvalid) && k < budget) begin
            @(negedge lbs_clk);
            k++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_tvalid", 32'(axis_tx_tvalid), 32'd0);
    endtask

    initial begin
        // ---- reset ----
        #2 rst = 1'b1;
        repeat (3) @(negedge lbs_clk);
        chk("rst_tvalid", 32'(axis_tx_tvalid), 32'd0);
        chk("rst_tlast", 32'(axis_tx_tlast), 32'd0);
        chk("rst_tdata", axis_tx_tdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", lbs_dout, 32'd0);
        rst = 1'b0;
        bus_rd(STAT, rd_val);
        chk("rst_status", rd_val, 32'd0);

        // ---- basic 4-word block, tready high ----
        bus_wr(CTRL, 32'h5555);
        load_seq(4);
        push_block(4);
        clear_stats();
        bus_wr(CTRL, 32'h8888);
        chk("busy_after_start", 32'(busy), 32'd1);
        drain(50);
        chk("first_vld_latency", 32'(first_vld_cyc - wr_cyc), 32'd2);
        chk("no_bubbles", 32'(last_xfer_cyc - first_xfer_cyc), 32'd3);
        chk("basic_xfers", 32'(xfers), 32'd4);
        chk("busy_after_done", 32'(busy), 32'd0);
        bus_rd(STAT, rd_val);
        chk("basic_status", rd_val, 32'h0004_0002);

        // ---- same block, tready toggling ----
        bus_wr(CTRL, 32'h5555);
        load_seq(4);
        push_block(4);
        clear_stats();
        rdy_toggle = 1'b1;
        bus_wr(CTRL, 32'h8888);
        drain(60);
        rdy_toggle = 1'b0;
        chk("toggle_xfers", 32'(xfers), 32'd4);
        bus_rd(STAT, rd_val);
        chk("toggle_status", rd_val, 32'h0004_0002);

        // ---- empty START, then full-depth block ----
        bus_wr(CTRL, 32'h5555);
        for (int i = 0; i < BUF_DEPTH; i++) begin
            model[i] = 32'hA500_0000 | 32'(i);
            bus_wr(16'(BUF_BASE + i), model[i]);
        end
        bus_wr(CTRL, 32'h5555);      // contents kept, length cleared
        clear_stats();
        bus_wr(CTRL, 32'h8888);
        repeat (6) @(negedge lbs_clk);
        chk("empty_no_vld", 32'(first_vld_cyc), 32'hFFFF_FFFF);
        bus_rd(STAT, rd_val);
        chk("empty_status", rd_val, 32'h0000_0004);
        model[BUF_DEPTH - 1] = 32'hDEAD_BEEF;
        bus_wr(16'(BUF_BASE + BUF_DEPTH - 1), model[BUF_DEPTH - 1]);
        push_block(BUF_DEPTH);
        clear_stats();
        bus_wr(CTRL, 32'h8888);
        drain(BUF_DEPTH + 100);
        chk("full_xfers", 32'(xfers), 32'(BUF_DEPTH));
        bus_rd(STAT, rd_val);
        chk("full_status", rd_val, 32'h0900_0006);

        // ---- overrun write and ABORT mid-stream ----
        bus_wr(CTRL, 32'h5555);
        load_seq(8);
        push_block(8);
        clear_stats();
        rdy_toggle = 1'b1;
        bus_wr(CTRL, 32'h8888);
        bus_wr(16'(BUF_BASE + 5), 32'h1234_5678);
        repeat (3) @(negedge lbs_clk);
        chk("vld_before_abort", 32'(axis_tx_tvalid), 32'd1);
        allow_drop = 1'b1;
        bus_wr(CTRL, 32'hFFFF);
        chk("abort_tvalid", 32'(axis_tx_tvalid), 32'd0);
        chk("abort_tlast", 32'(axis_tx_tlast), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_partial", 32'((xfers > 0) && (xfers < 8)), 32'd1);
        exp_q.delete();
        @(negedge lbs_clk);
        allow_drop = 1'b0;
        rdy_toggle = 1'b0;
        bus_rd(STAT, rd_val);
        chk("abort_status", rd_val, 32'h0008_0018);

        // ---- read-back latency and decoding ----
        @(negedge lbs_clk);
        lbs_addr = 16'(BUF_BASE + 1); lbs_re = 1'b1;
        @(negedge lbs_clk);
        lbs_re = 1'b0;
        @(posedge lbs_clk);
        #1 chk("rd_not_early", lbs_dout, 32'h0008_0018);
        @(posedge lbs_clk);
        #1 chk("rd_buf_idx1", lbs_dout, model[1]);
        bus_rd(16'd15000, rd_val);
        chk("rd_unmapped", rd_val, 32'd0);
        bus_rd(16'(BUF_BASE + 5), rd_val);
        chk("rd_overrun_dropped", rd_val, model[5]);
        bus_wr(CTRL, 32'h5555);
        @(negedge lbs_clk);
        lbs_addr = 16'(BUF_BASE + 1); lbs_din = 32'h99; lbs_we = 1'b1; lbs_re = 1'b1;
        @(negedge lbs_clk);
        lbs_we = 1'b0; lbs_re = 1'b0;
        repeat (3) @(negedge lbs_clk);
        chk("we_re_dout_hold", lbs_dout, model[5]);
        model[1] = 32'h99;
        bus_rd(16'(BUF_BASE + 1), rd_val);
        chk("we_re_write_landed", rd_val, 32'h99);

        // ---- replay from DONE, then reset mid-PLAY ----
        bus_wr(CTRL, 32'h5555);
        load_seq(4);
        push_block(4);
        bus_wr(CTRL, 32'h8888);
        drain(50);
        push_block(4);
        clear_stats();
        bus_wr(CTRL, 32'h8888);
        drain(50);
        chk("replay_xfers", 32'(xfers), 32'd4);
        bus_rd(STAT, rd_val);
        chk("replay_status", rd_val, 32'h0004_0002);
        push_block(4);
        bus_wr(CTRL, 32'h8888);
        repeat (2) @(negedge lbs_clk);
        chk("vld_before_rst", 32'(axis_tx_tvalid), 32'd1);
        #1 allow_drop = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_mid_tvalid", 32'(axis_tx_tvalid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge lbs_clk);
        rst = 1'b0;
        @(negedge lbs_clk);
        allow_drop = 1'b0;
        bus_rd(STAT, rd_val);
        chk("post_rst_status", rd_val, 32'd0);
        clear_stats();
        bus_wr(CTRL, 32'h8888);
        repeat (6) @(negedge lbs_clk);
        chk("idle_start_busy", 32'(busy), 32'd0);
        chk("idle_start_no_vld", 32'(first_vld_cyc), 32'hFFFF_FFFF);
        bus_rd(STAT, rd_val);
        chk("idle_start_ignored", rd_val, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
